mem_pipe_stage: RTL



---
 rtl/mem_pipe_stage_pkg.sv | 22 ++
 rtl/mem_pipe_stage_fwd_match.sv | 19 +
 rtl/mem_pipe_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pipe_stage_pkg.sv
// Shared definitions for the memory-pipeline stage: bus width and forwarding-field layout.
package mem_pipe_stage_pkg;

    localparam int EX_MEM_BUS_W = 114;
    localparam int FWD_RES_W    = 64;
    localparam int FWD_RD_W     = 5;

    localparam int RES_LSB = 0;
    localparam int RD_LSB  = RES_LSB + FWD_RES_W;
    localparam int WE_BIT  = RD_LSB + FWD_RD_W;

    typedef struct packed {
        logic                 we;
        logic [FWD_RD_W-1:0]  rd;
        logic [FWD_RES_W-1:0] res;
    } fwd_entry_t;

    function automatic fwd_entry_t fwd_entry_of(input logic [EX_MEM_BUS_W-1:0] bus);
        return bus[WE_BIT:RES_LSB];
    endfunction

endpackage

// File: rtl/mem_pipe_stage_fwd_match.sv
// Single held entry versus one lookup address: forwarding hit and gated result.
module mem_pipe_stage_fwd_match #(
    parameter int RES_W = 64,
    parameter int RD_W  = 5
) (
    input  logic             entry_v,
    input  logic             entry_we,
    input  logic [RD_W-1:0]  entry_rd,
    input  logic [RES_W-1:0] entry_res,
    input  logic [RD_W-1:0]  rs,
    output logic             hit,
    output logic [RES_W-1:0] data
);

    // Register 0 is hard-wired, so it never forwards.
    assign hit  = entry_v && entry_we && (entry_rd == rs) && (rs != {RD_W{1'b0}});
    assign data = hit ? entry_res : {RES_W{1'b0}};

endmodule

// File: rtl/mem_pipe_stage.sv
// Memory-pipeline stage register with valid/ready handshake, main+skid buffer,
// flush, forwarding lookup and a stall-cycle counter.
module mem_pipe_stage
    import mem_pipe_stage_pkg::*;
#(
    parameter int BUS_W  = EX_MEM_BUS_W,
    parameter int RES_W  = FWD_RES_W,
    parameter int RD_W   = FWD_RD_W,
    parameter int NUM_LK = 2,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BUS_W-1:0]        in_bus,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BUS_W-1:0]        out_bus,
    input  logic [NUM_LK*RD_W-1:0]  lk_rs,
    output logic [NUM_LK-1:0]       lk_hit,
    output logic [NUM_LK*RES_W-1:0] lk_data,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int WE_POS = RES_W + RD_W;

    logic             main_v;
    logic             skid_v;
    logic [BUS_W-1:0] main_bus;
    logic [BUS_W-1:0] skid_bus;
    logic             acc;
    logic             pop;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = !skid_v;
    assign acc       = in_valid && in_ready && !flush;
    assign pop       = main_v && out_ready;
    assign out_valid = main_v;
    assign out_bus   = main_bus;

    // Two-entry buffer: main is always the oldest entry, skid the younger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_bus <= {BUS_W{1'b0}};
            skid_bus <= {BUS_W{1'b0}};
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            case ({main_v, skid_v})
                2'b00: begin
                    if (acc) begin
                        main_v   <= 1'b1;
                        main_bus <= in_bus;
                    end
                end
                2'b10: begin
                    if (pop && acc) begin
                        main_bus <= in_bus;
                    end else if (pop) begin
                        main_v <= 1'b0;
                    end else if (acc) begin
                        skid_v   <= 1'b1;
                        skid_bus <= in_bus;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        main_bus <= skid_bus;
                        skid_v   <= 1'b0;
                    end
                end
                default: begin
                    // Skid without main is unreachable; recover to empty.
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

    // Stall counter wraps naturally and ignores flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
        end else if (main_v && !out_ready) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    for (genvar k = 0; k < NUM_LK; k++) begin : g_lk
        logic             skid_hit;
        logic             main_hit;
        logic [RES_W-1:0] skid_data;
        logic [RES_W-1:0] main_data;

        mem_pipe_stage_fwd_match #(.RES_W(RES_W), .RD_W(RD_W)) u_skid (
            .entry_v   (skid_v),
            .entry_we  (skid_bus[WE_POS]),
            .entry_rd  (skid_bus[RES_W +: RD_W]),
            .entry_res (skid_bus[RES_W-1:0]),
            .rs        (lk_rs[k*RD_W +: RD_W]),
            .hit       (skid_hit),
            .data      (skid_data)
        );

        mem_pipe_stage_fwd_match #(.RES_W(RES_W), .RD_W(RD_W)) u_main (
            .entry_v   (main_v),
            .entry_we  (main_bus[WE_POS]),
            .entry_rd  (main_bus[RES_W +: RD_W]),
            .entry_res (main_bus[RES_W-1:0]),
            .rs        (lk_rs[k*RD_W +: RD_W]),
            .hit       (main_hit),
            .data      (main_data)
        );

        // Younger (skid) entry wins when both hold the same register.
        assign lk_hit[k]                 = skid_hit || main_hit;
        assign lk_data[k*RES_W +: RES_W] = skid_hit ? skid_data : main_data;
    end

endmodule
